// File: rtl/idma_obi_ch_arbiter.sv
// idma_obi_ch_arbiter
// Merges the two iDMA channel OBI ports (ch0 = AXI2OBI writes, ch1 = OBI2AXI
// reads) onto the single OBI port toward the tile L1 interconnect. Request
// phases are arbitrated round-robin. A waiting request is locked so that its
// a-fields stay stable until granted. Responses come back in order and are
// steered by a 1-bit ID FIFO that records the granted channel of every
// outstanding transaction.
//
// Build option:
//   IDMA_OBI_ARB_FIXED_PRIO_EN - when defined, the round-robin pointer is
//   removed and channel 0 always wins unlocked contention. Locking is the same.
//
// The package below provides the default OBI request/response structs.

package magia_tile_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } idma_obi_a_chan_t;

    typedef struct packed {
        logic             req;
        idma_obi_a_chan_t a;
    } idma_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } idma_obi_r_chan_t;

    typedef struct packed {
        logic             gnt;
        logic             rvalid;
        idma_obi_r_chan_t r;
    } idma_obi_rsp_t;

endpackage

// Handshake semantics: a request phase completes on the cycle where req and
// gnt are both high at the clock edge. The channel keeps req and its a-fields
// stable until that cycle. A response phase is the single cycle in which
// rvalid is high; there is no back-pressure on responses.
module idma_obi_ch_arbiter #(
    parameter int unsigned NumOutstanding = 4,
    parameter type         obi_req_t      = magia_tile_pkg::idma_obi_req_t,
    parameter type         obi_rsp_t      = magia_tile_pkg::idma_obi_rsp_t
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  obi_req_t [1:0] ch_obi_req_i,
    output obi_rsp_t [1:0] ch_obi_rsp_o,
    output obi_req_t       obi_req_o,
    input  obi_rsp_t       obi_rsp_i,
    output logic           busy_o
);

    localparam int unsigned PtrW = $clog2(NumOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic [1:0]          ch_req;
    logic                sel_idx;
    logic                sel_valid;
    logic                req_out;
    logic                handshake;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_head;

    logic                lock_q;
    logic                lock_idx_q;
`ifndef IDMA_OBI_ARB_FIXED_PRIO_EN
    logic                rr_ptr_q;
`endif

    logic [NumOutstanding-1:0] fifo_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           count_q;

    assign ch_req = {ch_obi_req_i[1].req, ch_obi_req_i[0].req};

    // Full/empty come from the registered count only, so a pop in this
    // cycle never frees a slot for a push in the same cycle.
    assign fifo_full  = (count_q == CntW'(NumOutstanding));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_q[rd_ptr_q];

    assign req_out   = sel_valid & ~fifo_full;
    assign handshake = req_out & obi_rsp_i.gnt;
    assign push      = handshake;
    assign pop       = obi_rsp_i.rvalid & ~fifo_empty;

    assign busy_o = lock_q | ~fifo_empty;

    // Pick the channel to present: the locked one, else the preferred requester.
    always_comb begin
        sel_idx   = 1'b0;
        sel_valid = 1'b0;
        if (lock_q) begin
            sel_idx   = lock_idx_q;
            sel_valid = ch_req[lock_idx_q];
        end else begin
            sel_valid = |ch_req;
`ifdef IDMA_OBI_ARB_FIXED_PRIO_EN
            sel_idx = ~ch_req[0] & ch_req[1];
`else
            sel_idx = ch_req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
`endif
        end
    end

    // Forward the selected channel's request phase, gated by FIFO space.
    always_comb begin
        obi_req_o     = ch_obi_req_i[sel_idx];
        obi_req_o.req = req_out;
    end

    // Route gnt to the selected channel and rvalid to the FIFO head channel.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ch_obi_rsp_o[k]        = obi_rsp_i;
            ch_obi_rsp_o[k].gnt    = handshake & (sel_idx == 1'(k));
            ch_obi_rsp_o[k].rvalid = pop & (fifo_head == 1'(k));
        end
    end

    // Lock the selection while a presented request waits for gnt; advance
    // the round-robin pointer past the winner on every handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
`ifndef IDMA_OBI_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            if (handshake) begin
                lock_q   <= 1'b0;
`ifndef IDMA_OBI_ARB_FIXED_PRIO_EN
                rr_ptr_q <= ~sel_idx;
`endif
            end else if (req_out) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel_idx;
            end
        end
    end

    // ID FIFO: remember the granted channel of each outstanding transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel_idx;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; flag it in simulation.
    a_rvalid_needs_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni) obi_rsp_i.rvalid |-> !fifo_empty
    );
`endif

endmodule

// File: tb/tb_idma_obi_ch_arbiter.sv
// Bench for idma_obi_ch_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level model that keeps
// the outstanding channel IDs in a queue.
module tb_idma_obi_ch_arbiter;

    localparam int N_OUT = 2;

    typedef magia_tile_pkg::idma_obi_req_t req_t;
    typedef magia_tile_pkg::idma_obi_rsp_t rsp_t;

    logic           clk;
    logic           rst_n;
    req_t [1:0]     ch_req;
    rsp_t [1:0]     ch_rsp;
    req_t           obi_req;
    rsp_t           obi_rsp;
    logic           busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: outstanding channel IDs in issue order, pending-lock
    // record, and the channel that gets preference next.
    logic [0:0] exp_q[$];
    bit         m_locked;
    int         m_lock_idx;
    int         m_pref;
    bit         m_hs;
    int         m_hs_idx;
    int         m_sel;
    bit         m_req;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    idma_obi_ch_arbiter #(
        .NumOutstanding (N_OUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ch_obi_req_i (ch_req),
        .ch_obi_rsp_o (ch_rsp),
        .obi_req_o    (obi_req),
        .obi_rsp_i    (obi_rsp),
        .busy_o       (busy)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ch(input int k, input bit req, input logic [31:0] addr);
        ch_req[k].req     = req;
        ch_req[k].a.addr  = addr;
        ch_req[k].a.we    = (k == 0);
        ch_req[k].a.be    = 4'hf;
        ch_req[k].a.wdata = addr ^ 32'hA5A5_0000;
        ch_req[k].a.aid   = 4'(k);
    endtask

    task automatic drive_rsp(input bit gnt, input bit rvalid);
        obi_rsp.gnt     = gnt;
        obi_rsp.rvalid  = rvalid;
        obi_rsp.r.rdata = $urandom;
        obi_rsp.r.rid   = 4'($urandom_range(0, 15));
        obi_rsp.r.err   = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_locked   = 1'b0;
        m_lock_idx = 0;
        m_pref     = 0;
        m_hs       = 1'b0;
        m_hs_idx   = 0;
    endtask

    // Evaluate the expected outputs for the inputs now applied and compare.
    task automatic settle_and_check();
        int  order[2];
        bit  any;
        #1;
`ifdef IDMA_OBI_ARB_FIXED_PRIO_EN
        order[0] = 0;
`else
        order[0] = m_pref;
`endif
        order[1] = 1 - order[0];
        any = ch_req[0].req || ch_req[1].req;
        if (m_locked) begin
            m_sel = m_lock_idx;
            any   = ch_req[m_lock_idx].req;
        end else begin
            m_sel = order[0];
            if (!ch_req[order[0]].req && ch_req[order[1]].req) m_sel = order[1];
        end
        m_req = any && (exp_q.size() < N_OUT);

        check_eq("obi_req", 32'(obi_req.req), 32'(m_req));
        if (any) begin
            check_eq("obi_addr", obi_req.a.addr, ch_req[m_sel].a.addr);
            check_eq("obi_wdata", obi_req.a.wdata, ch_req[m_sel].a.wdata);
            check_eq("obi_we", 32'(obi_req.a.we), 32'(ch_req[m_sel].a.we));
        end
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("ch%0d_gnt", k), 32'(ch_rsp[k].gnt),
                     32'(m_req && obi_rsp.gnt && (m_sel == k)));
            check_eq($sformatf("ch%0d_rvalid", k), 32'(ch_rsp[k].rvalid),
                     32'(obi_rsp.rvalid && (exp_q.size() > 0) && (int'(exp_q[0]) == k)));
            check_eq($sformatf("ch%0d_rdata", k), ch_rsp[k].r.rdata, obi_rsp.r.rdata);
        end
        check_eq("busy", 32'(busy), 32'(m_locked || (exp_q.size() > 0)));
    endtask

    // Clock edge: apply the transaction-level effects, then return at negedge.
    task automatic advance();
        @(posedge clk);
        m_hs     = m_req && obi_rsp.gnt;
        m_hs_idx = m_sel;
        if (obi_rsp.rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_hs) begin
            exp_q.push_back(1'(m_sel));
            m_pref   = 1 - m_sel;
            m_locked = 1'b0;
        end else if (m_req) begin
            m_locked   = 1'b1;
            m_lock_idx = m_sel;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle_and_check();
        advance();
    endtask

    task automatic drain();
        drive_ch(0, 1'b0, 32'h0);
        drive_ch(1, 1'b0, 32'h0);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            drive_rsp(1'b0, 1'b1);
            cycle();
        end
        drive_rsp(1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          pend[2];
        logic [31:0] paddr[2];
        int          win;

        rst_n = 1'b0;
        drive_ch(0, 1'b0, 32'h0);
        drive_ch(1, 1'b0, 32'h0);
        drive_rsp(1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);

        // Reset values
        #1;
        check_eq("rst_obi_req", 32'(obi_req.req), 32'd0);
        check_eq("rst_ch0_gnt", 32'(ch_rsp[0].gnt), 32'd0);
        check_eq("rst_ch1_gnt", 32'(ch_rsp[1].gnt), 32'd0);
        check_eq("rst_ch0_rvalid", 32'(ch_rsp[0].rvalid), 32'd0);
        check_eq("rst_ch1_rvalid", 32'(ch_rsp[1].rvalid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from ch0, granted at once, answered two cycles later
        drive_ch(0, 1'b1, 32'h0000_0100);
        drive_rsp(1'b1, 1'b0);
        settle_and_check();
        check_eq("t1_ch0_gnt", 32'(ch_rsp[0].gnt), 32'd1);
        check_eq("t1_addr", obi_req.a.addr, 32'h0000_0100);
        advance();
        drive_ch(0, 1'b0, 32'h0);
        drive_rsp(1'b0, 1'b0);
        settle_and_check();
        check_eq("t1_busy_c1", 32'(busy), 32'd1);
        advance();
        drive_rsp(1'b0, 1'b1);
        settle_and_check();
        check_eq("t1_ch0_rvalid", 32'(ch_rsp[0].rvalid), 32'd1);
        check_eq("t1_ch1_rvalid", 32'(ch_rsp[1].rvalid), 32'd0);
        check_eq("t1_busy_c2", 32'(busy), 32'd1);
        advance();
        drive_rsp(1'b0, 1'b0);
        settle_and_check();
        check_eq("t1_busy_idle", 32'(busy), 32'd0);
        advance();

        // Both channels requesting continuously, gnt always high.
        // Channel 0 won last, so channel 1 is preferred first.
        for (int i = 0; i < 8; i++) begin
            drive_ch(0, 1'b1, 32'h1000 + 32'(i));
            drive_ch(1, 1'b1, 32'h2000 + 32'(i));
            drive_rsp(1'b1, i > 0);
            settle_and_check();
`ifdef IDMA_OBI_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = (i % 2 == 0) ? 1 : 0;
`endif
            check_eq($sformatf("t2_gnt_ch%0d_i%0d", win, i), 32'(ch_rsp[win].gnt), 32'd1);
            check_eq($sformatf("t2_nogn_ch%0d_i%0d", 1 - win, i), 32'(ch_rsp[1 - win].gnt), 32'd0);
            advance();
        end
        drain();

        // ch1 at 0x40 waits 5 cycles for gnt while ch0 also requests
        drive_ch(0, 1'b0, 32'h0);
        drive_ch(1, 1'b1, 32'h0000_0040);
        drive_rsp(1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive_ch(0, 1'b1, 32'h0000_0200);
            settle_and_check();
            check_eq($sformatf("t3_addr_hold%0d", i), obi_req.a.addr, 32'h0000_0040);
            advance();
        end
        drive_rsp(1'b1, 1'b0);
        settle_and_check();
        check_eq("t3_addr_gnt", obi_req.a.addr, 32'h0000_0040);
        check_eq("t3_ch1_gnt", 32'(ch_rsp[1].gnt), 32'd1);
        check_eq("t3_ch0_nogn", 32'(ch_rsp[0].gnt), 32'd0);
        advance();
        drive_ch(1, 1'b0, 32'h0);
        drive_rsp(1'b1, 1'b1);
        settle_and_check();
        check_eq("t3_ch0_gnt", 32'(ch_rsp[0].gnt), 32'd1);
        check_eq("t3_ch1_rvalid", 32'(ch_rsp[1].rvalid), 32'd1);
        advance();
        drain();

        // Full FIFO: two handshakes, then req blocked until a pop registers
        drive_ch(0, 1'b1, 32'h300);
        drive_rsp(1'b1, 1'b0);
        cycle();
        drive_ch(0, 1'b1, 32'h304);
        cycle();
        drive_ch(0, 1'b1, 32'h308);
        drive_rsp(1'b1, 1'b0);
        settle_and_check();
        check_eq("t4_full_req", 32'(obi_req.req), 32'd0);
        advance();
        drive_rsp(1'b1, 1'b1);
        settle_and_check();
        check_eq("t4_pop_same_cycle_req", 32'(obi_req.req), 32'd0);
        check_eq("t4_pop_ch0_gnt", 32'(ch_rsp[0].gnt), 32'd0);
        advance();
        drive_rsp(1'b1, 1'b0);
        settle_and_check();
        check_eq("t4_reassert_req", 32'(obi_req.req), 32'd1);
        advance();
        drain();

        // Same-cycle push and pop with one outstanding
        drive_ch(0, 1'b1, 32'h400);
        drive_rsp(1'b1, 1'b0);
        cycle();
        drive_ch(0, 1'b0, 32'h0);
        drive_ch(1, 1'b1, 32'h500);
        drive_rsp(1'b1, 1'b1);
        settle_and_check();
        check_eq("t5_ch0_rvalid", 32'(ch_rsp[0].rvalid), 32'd1);
        check_eq("t5_ch1_gnt", 32'(ch_rsp[1].gnt), 32'd1);
        advance();
        drive_ch(1, 1'b0, 32'h0);
        drive_rsp(1'b0, 1'b1);
        settle_and_check();
        check_eq("t5_ch1_rvalid", 32'(ch_rsp[1].rvalid), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd1);
        advance();
        drive_rsp(1'b0, 1'b0);
        settle_and_check();
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        advance();

        // Reset mid-stream with outstanding transactions and a pending lock
        drive_ch(0, 1'b1, 32'h600);
        drive_ch(1, 1'b1, 32'h700);
        drive_rsp(1'b1, 1'b0);
        cycle();
        drive_rsp(1'b0, 1'b0);
        cycle();
        rst_n = 1'b0;
        drive_ch(0, 1'b0, 32'h0);
        drive_ch(1, 1'b0, 32'h0);
        model_reset();
        #1;
        check_eq("t6_rst_obi_req", 32'(obi_req.req), 32'd0);
        check_eq("t6_rst_ch0_gnt", 32'(ch_rsp[0].gnt), 32'd0);
        check_eq("t6_rst_ch1_gnt", 32'(ch_rsp[1].gnt), 32'd0);
        check_eq("t6_rst_ch0_rvalid", 32'(ch_rsp[0].rvalid), 32'd0);
        check_eq("t6_rst_ch1_rvalid", 32'(ch_rsp[1].rvalid), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle();

        // Randomized traffic; a channel holds its request until granted
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        paddr[0] = 32'h0;
        paddr[1] = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 99) < 55) begin
                    pend[k]  = 1'b1;
                    paddr[k] = {$urandom_range(0, 16'hffff), 2'b00, 14'(k)};
                end
                drive_ch(k, pend[k], paddr[k]);
            end
            drive_rsp($urandom_range(0, 3) != 0,
                      (exp_q.size() > 0) && ($urandom_range(0, 1) == 1));
            cycle();
            if (m_hs) pend[m_hs_idx] = 1'b0;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
